// File: rtl/apb_dmem_pkg.sv
// Shared widths, wait-counter width and FSM state type for the APB data memory.
package apb_dmem_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StReady
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, Depth x DATA_W, with one write enable and a registered read.
// Storage has no reset; only the read register does.
module dmem_array
  import apb_dmem_pkg::*;
#(
  parameter int unsigned Depth = 256,
  parameter int unsigned IdxW  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic              re_i,
  input  logic              rd_zero_i,
  input  logic [IdxW-1:0]   addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [Depth];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  // rd_zero_i forces an error response to return zero instead of stale storage.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = rd_zero_i ? '0 : mem[addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_dmem.sv
// APB slave data memory with programmable wait states (FSM, counter, latches, range check).
// Define APB_DMEM_PSLVERR_EN to flag out-of-range accesses on pslverr instead of wrapping.
module apb_dmem
  import apb_dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] WaitLoad = CNT_W'(WAIT_CYCLES);

  dmem_state_t       state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [IdxW-1:0]   addr_d, addr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic              write_d, write_q;
  logic              oor_d, oor_q;
  logic              pready_d, pready_q;
  logic              err_d, err_q;
  logic              enter;

  logic              paddr_oor;
  logic              from_bus;
  logic [IdxW-1:0]   acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_wr, acc_oor;

`ifdef APB_DMEM_PSLVERR_EN
  assign paddr_oor = (32'(paddr) >= DEPTH);
`else
  logic unused_paddr;
  assign unused_paddr = ^paddr;
  assign paddr_oor    = 1'b0;
`endif

  // With no wait states READY is entered on the setup edge, before the latches hold the access.
  assign from_bus  = (state_q == StIdle);
  assign acc_addr  = from_bus ? paddr[IdxW-1:0] : addr_q;
  assign acc_wdata = from_bus ? pwdata : wdata_q;
  assign acc_wr    = from_bus ? pwrite : write_q;
  assign acc_oor   = from_bus ? paddr_oor : oor_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    oor_d    = oor_q;
    pready_d = pready_q;
    err_d    = err_q;
    enter    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // psel with penable already high is a stale access and is ignored.
        if (psel && !penable) begin
          addr_d  = paddr[IdxW-1:0];
          wdata_d = pwdata;
          write_d = pwrite;
          oor_d   = paddr_oor;
          cnt_d   = WaitLoad;
          if (WAIT_CYCLES == 0) begin
            enter = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!psel) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            enter = 1'b1;
          end
        end
      end
      StReady: begin
        if (!(psel && penable)) begin
          state_d  = StIdle;
          pready_d = 1'b0;
          err_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (enter) begin
      state_d  = StReady;
      pready_d = 1'b1;
      err_d    = acc_oor;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      oor_q    <= 1'b0;
      pready_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      oor_q    <= oor_d;
      pready_q <= pready_d;
      err_q    <= err_d;
    end
  end

  dmem_array #(
    .Depth (DEPTH),
    .IdxW  (IdxW)
  ) u_array (
    .clk_i     (clk),
    .rst_ni    (reset),
    .we_i      (enter && acc_wr && !acc_oor),
    .re_i      (enter && !acc_wr),
    .rd_zero_i (acc_oor),
    .addr_i    (acc_addr),
    .wdata_i   (acc_wdata),
    .rdata_o   (prdata)
  );

  assign pready  = pready_q;
  assign pslverr = err_q;

endmodule

// File: tb/tb_apb_dmem.sv
// Bench for apb_dmem: one instance with one wait state and one with none, sharing the bus inputs.
module tb_apb_dmem;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [15:0] paddr = '0, pwdata = '0;
  logic        pready, pslverr, pready0, pslverr0;
  logic [15:0] prdata, prdata0;
  int          total = 0;
  int          bad = 0;

`ifdef APB_DMEM_PSLVERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  always #5 clk = ~clk;

  apb_dmem #(.DEPTH(256), .WAIT_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  apb_dmem #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready0), .prdata(prdata0), .pslverr(pslverr0)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic        is_rd;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] exp_rd, input logic exp_err, input bit chk0);
    exp_t e;
    int   n;
    e.is_rd = !wr;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb.push_back(e);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    chk1("ws1_first_access_pready", pready, 1'b0);
    if (chk0) begin
      chk1("ws0_pready", pready0, 1'b1);
      chk1("ws0_pslverr", pslverr0, exp_err);
      if (!wr) chk("ws0_prdata", prdata0, exp_rd);
    end
    n = 0;
    while (!pready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ws1_latency", 16'(n), 16'd1);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk1("ws1_pslverr", pslverr, e.err);
      if (e.is_rd) chk("ws1_prdata", prdata, e.rdata);
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    chk1("pready_clears", pready, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 16'h0012, 16'hBEEF, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 16'h0012, 16'h0000, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b1, 16'h0000, 16'h1234, 16'h0000, 1'b0};
    vecs[3] = '{1'b0, 16'h0000, 16'h0000, 16'h1234, 1'b0};
    vecs[4] = '{1'b1, 16'h00FF, 16'h5A5A, 16'h0000, 1'b0};
    vecs[5] = '{1'b0, 16'h00FF, 16'h0000, 16'h5A5A, 1'b0};
    vecs[6] = '{1'b1, 16'h0100, 16'hAAAA, 16'h0000, ErrEn};
    vecs[7] = '{1'b0, 16'h0000, 16'h0000, ErrEn ? 16'h1234 : 16'hAAAA, 1'b0};
    vecs[8] = '{1'b0, 16'h0100, 16'h0000, ErrEn ? 16'h0000 : 16'hAAAA, ErrEn};
    vecs[9] = '{1'b1, 16'h0005, 16'h0505, 16'h0000, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk1("reset_pready", pready, 1'b0);
    chk("reset_prdata", prdata, 16'h0000);
    chk1("reset_pslverr", pslverr, 1'b0);
    chk1("reset_pready0", pready0, 1'b0);
    chk("reset_prdata0", prdata0, 16'h0000);
    reset = 1'b1;
    @(posedge clk); #1;
    chk1("post_reset_pready", pready, 1'b0);

    for (int i = 0; i < 10; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err, 1'b1);
    end

    // Late master: hold the access, change pwdata mid-hold, then present a stale access.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0020; pwdata = 16'h1111;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    chk1("late_ready", pready, 1'b1);
    pwdata = 16'h2222;
    repeat (3) begin
      @(posedge clk); #1;
      chk1("late_hold", pready, 1'b1);
      chk1("late_hold0", pready0, 1'b1);
    end
    psel = 1'b0;
    @(posedge clk); #1;
    chk1("late_release", pready, 1'b0);
    psel = 1'b1; pwdata = 16'h3333;
    repeat (3) begin
      @(posedge clk); #1;
      chk1("stale_ignored", pready, 1'b0);
      chk1("stale_ignored0", pready0, 1'b0);
    end
    psel = 1'b0; penable = 1'b0;
    xfer(1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0, 1'b1);

    // Abort a write during the wait state; the one-wait instance must not commit it.
    xfer(1'b1, 16'h0030, 16'h0001, 16'h0000, 1'b0, 1'b1);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0030; pwdata = 16'h7777;
    @(posedge clk); #1;
    psel = 1'b0;
    chk1("abort_wait", pready, 1'b0);
    @(posedge clk); #1;
    chk1("abort_no_ready", pready, 1'b0);
    xfer(1'b0, 16'h0030, 16'h0000, 16'h0001, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a read's wait state.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0012;
    @(posedge clk); #1;
    penable = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk1("async_reset_pready", pready, 1'b0);
    chk("async_reset_prdata", prdata, 16'h0000);
    chk1("async_reset_pready0", pready0, 1'b0);
    chk("async_reset_prdata0", prdata0, 16'h0000);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    xfer(1'b0, 16'h0005, 16'h0000, 16'h0505, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_dmem.md
# apb_dmem

APB slave data memory sitting directly downstream of the CPU's ALU/load-store stage on the `apb_bus` interface. Serves LW reads and SW writes with 16-bit word-addressed storage and a programmable number of wait states. Drives `pready`/`prdata` back to the load-store FSM, which holds `psel` until it samples `pready`.

## Interface
Parameters:
- `DEPTH`, 256: number of 16-bit words; power of two, 2..65536.
- `WAIT_CYCLES`, 1: extra access-phase cycles before `pready`; 0..15.

Ports (slave side of `apb_bus pbus`, members listed individually):
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pbus.psel`  in  1  slave select.
- `pbus.penable`  in  1  access phase.
- `pbus.pwrite`  in  1  1 = write (SW), 0 = read (LW).
- `pbus.paddr`  in  16  word address.
- `pbus.pwdata`  in  16  write data.
- `pbus.pready`  out  1  transfer complete; registered.
- `pbus.prdata`  out  16  read data; registered, valid while `pready`=1 on reads.
- `pbus.pslverr`  out  1  out-of-range error (see Configuration).

## Operation
- FSM states: IDLE, WAIT, READY.
- IDLE: on `psel`=1 and `penable`=0 (setup phase), latch `paddr`, `pwrite`, `pwdata`, and load the wait counter with `WAIT_CYCLES`. If `WAIT_CYCLES`=0, go to READY; otherwise go to WAIT.
- IDLE with `psel`=1 and `penable`=1 is a stale access left over from a finished transfer. It is ignored: the FSM stays in IDLE and `pready` stays 0. A new transfer requires a fresh setup phase.
- WAIT: decrement the counter each cycle. On the edge where the counter equals 1, go to READY. If `psel` drops, abort to IDLE with no write.
- Entry into READY happens on a single edge, on which the block:
  - asserts `pready`;
  - for a read, registers `mem[addr]` into `prdata`;
  - for a write, commits `pwdata` to `mem[addr]` exactly once.
- READY: hold `pready`=1 and `prdata` stable while `psel`=1 and `penable`=1. This tolerates a master that samples `pready` late. When either signal drops, return to IDLE and clear `pready` on that edge.
- Address index is `paddr[$clog2(DEPTH)-1:0]`. An address is out of range when `paddr` >= `DEPTH`.
- `prdata` keeps its last value outside READY. It is never X after reset.
- Memory contents are not reset.

## Timing
- Reset values: `pready`=0, `prdata`=16'h0000, `pslverr`=0, state=IDLE, counter=0.
- Reset assertion is asynchronous. A transfer in progress is dropped immediately, and a write not yet committed is lost.
- Reset deassertion is sampled on the next rising edge of `clk`.
- Setup phase at cycle T; first access cycle is T+1. `pready` is high from cycle T+1+`WAIT_CYCLES`.
- Read data appears in the same cycle as `pready`.
- Write data is visible to a read whose setup phase starts one cycle after the write's `pready` cycle.
- Minimum transfer is 2 cycles plus `WAIT_CYCLES`. Back-to-back transfers need `psel` or `penable` low for at least one cycle between them.

## Configuration
- Macro `APB_DMEM_PSLVERR_EN`.
- Defined: an out-of-range access completes normally (same `pready` timing), with `pslverr`=1 for the READY cycles. The write is suppressed and `prdata`=16'h0000.
- Undefined: `pslverr` is tied 0. Addresses wrap modulo `DEPTH` through the index bits and all accesses succeed.

## Structure
- Package `apb_dmem_pkg` holds:
  - `DATA_W`=16 and `ADDR_W`=16;
  - the `dmem_state_t` enum (IDLE, WAIT, READY);
  - the wait-counter width constant (4 bits).
- Sub-module `dmem_array`: single-port synchronous RAM, `DEPTH`x16, with one write enable and a registered read. Keeps storage separable for FPGA BRAM inference.
- `apb_dmem` contains only the FSM, counter, latches and range check.

## Test plan
- Reset: assert `reset`=0 mid-WAIT -> `pready`=0 and `prdata`=0 at once. Release, then LW addr 5 -> completes normally.
- SW then LW, `WAIT_CYCLES`=1: write 16'hBEEF to addr 16'h0012, then read it -> `pready` high at T+2 both times; read returns 16'hBEEF.
- `WAIT_CYCLES`=0: LW addr 0 after preloading 16'h1234 -> `pready` and `prdata`=16'h1234 in the first access cycle.
- Late master: hold `psel`=`penable`=1 for 3 cycles after `pready` -> `pready` stays high, a single write occurs, and the FSM ignores the stale access until `penable` drops.
- Out of range, `DEPTH`=256, SW 16'h0100 with data 16'hAAAA:
  - with `APB_DMEM_PSLVERR_EN` -> `pslverr`=1 and addr 0 is unchanged;
  - without it -> addr 0 reads back 16'hAAAA.
- Abort: drop `psel` during WAIT on a SW -> no write, and the FSM is back in IDLE on the next edge.
